load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  CPU-side initiator for the 32-bit data memory (byte-lane banks, separate read/write addresses).
//  Accepts one load/store request at a time from the datapath and drives raddress/waddress/Datain/Wr.
//  Captures Dataout and returns extracted, sign/zero-extended load data, or a store acknowledge.
//  Sub-word stores are done as read-modify-write so the memory is always written with all four lanes.
// PARAMETERS
//  READ_LAT  1  cycles from a stable mem_raddress to valid mem_dataout; legal range 1..7
// PORTS
//  Clk            in   1   clock, rising edge
//  Rst_n          in   1   asynchronous active-low reset
//  req_valid      in   1   request present
//  req_ready      out  1   unit can accept; high only in IDLE
//  req_we         in   1   1 = store, 0 = load
//  req_size       in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned   in   1   loads: 1 = zero-extend, 0 = sign-extend
//  req_addr       in   32  byte address
//  req_wdata      in   32  store data; byte/half taken from the low bits
//  resp_valid     out  1   one-cycle completion pulse
//  resp_rdata     out  32  load result; 0 for stores and errors
//  resp_err       out  1   high with resp_valid when req_size == 11
//  mem_raddress   out  32  to memory raddress
//  mem_waddress   out  32  to memory waddress
//  mem_datain     out  32  to memory Datain
//  mem_wr         out  4   to memory Wr; only 4'b0000 or 4'b1111
//  mem_dataout    in   32  from memory Dataout; byte A+k is on lane k
// BEHAVIOUR
//  - Clock and reset: single clock Clk; Rst_n is asynchronous and active-low.
//  - Reset: state=IDLE, all registers 0.
//    - req_ready=1 once Rst_n is high; resp_valid=0, resp_err=0, resp_rdata=0.
//    - mem_wr=0 and all mem_* address/data outputs are 0.
//    - mem_wr is decoded from the state register only, so it drops with reset immediately.
//  - Accept: on req_valid && req_ready at a rising edge, register addr/size/we/unsigned/wdata.
//    Request inputs are don't-care at all other times.
//  - FSM: IDLE, RD_WAIT, WRITE, RESP.
//    - IDLE -> RESP when size==11 (no memory access, resp_err=1).
//    - IDLE -> WRITE for a word store.
//    - IDLE -> RD_WAIT for a load or a sub-word store.
//    - RD_WAIT: mem_raddress=addr; a counter runs READ_LAT cycles; on the last cycle mem_dataout is captured.
//      Then -> RESP for a load, -> WRITE for a store.
//    - WRITE: exactly one cycle with mem_wr=4'b1111 and mem_waddress=addr. -> RESP.
//      - Word store: mem_datain = wdata.
//      - Byte store: captured word with [7:0] replaced by wdata[7:0].
//      - Half store: captured word with [15:0] replaced by wdata[15:0].
//    - RESP: resp_valid=1 for one cycle. -> IDLE.
//  - Load extraction: byte = captured[7:0], half = captured[15:0], word = captured.
//    Bit 7 or bit 15 is replicated into the upper bits unless req_unsigned; word loads ignore req_unsigned.
//  - Alignment: no alignment check; any address is legal, and the memory wraps addresses internally.
//  - Latency from the accept edge to the resp_valid cycle:
//    - word store: 2 cycles
//    - load: READ_LAT+1 cycles
//    - sub-word store: READ_LAT+2 cycles
//    - illegal size: 1 cycle
//  - mem_wr=0 in every state except WRITE. The address and data outputs hold their last value when unused.
//  - resp_rdata/resp_err are valid only with resp_valid and are cleared to 0 in the cycle after it.
//  - There is no response backpressure; the datapath must sample the resp_valid pulse.
//  - Reset mid-operation: the FSM goes to IDLE and no resp_valid is produced.
//    A write-in-progress is aborted with mem_wr=0 before the next edge.
// TESTING (memory model with READ_LAT=1)
//  Reset: hold Rst_n=0 -> req_ready=0, resp_valid=0, mem_wr=0; release -> req_ready=1 next cycle.
//  sw 0xDEADBEEF to 0x100, then lw 0x100
//    -> exactly one mem_wr=1111 cycle; load resp_valid 2 cycles after accept, resp_rdata=0xDEADBEEF.
//  After the above: lb/lbu/lh/lhu at 0x100 -> 0xFFFFFFEF / 0x000000EF / 0xFFFFBEEF / 0x0000BEEF.
//  sb 0x12 to 0x100, then sh 0x5678 to 0x100
//    -> mem_datain 0xDEADBE12 then 0xDEAD5678, each with mem_wr=1111; lw returns 0xDEAD5678.
//  req_size=11 store -> mem_wr never set; resp_valid and resp_err=1 one cycle after accept; resp_rdata=0.
//  Pull Rst_n low during the WRITE cycle of an sb
//    -> mem_wr=0 immediately, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: CPU-side initiator for a 32-bit byte-lane data memory.
// Accepts one load/store at a time, reads/writes memory, returns extended
// load data or a store acknowledge. Sub-word stores use read-modify-write
// so the memory always sees full-word writes.
// Ports:
//   Clk, Rst_n                      clock, async active-low reset
//   req_valid/req_ready/req_*       request handshake and payload
//   resp_valid/resp_rdata/resp_err  one-cycle completion pulse
//   mem_raddress/mem_waddress       memory read / write addresses
//   mem_datain/mem_wr/mem_dataout   memory write data, lane enables, read data
module load_store_unit #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_raddress,
  output logic [31:0] mem_waddress,
  output logic [31:0] mem_datain,
  output logic [3:0]  mem_wr,
  input  logic [31:0] mem_dataout
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [1:0]       size_q, size_d;
  logic             we_q, we_d;
  logic             uns_q, uns_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             ready_q, ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;
  logic             resp_err_q, resp_err_d;
  logic [31:0]      raddr_q, raddr_d;
  logic [31:0]      waddr_q, waddr_d;
  logic [31:0]      datain_q, datain_d;
  logic [31:0]      load_c;
  logic [31:0]      merge_c;

  // Load extraction from the captured word
  always_comb begin
    load_c = rdata_q;
    case (size_q)
      2'b00:   load_c = uns_q ? {24'b0, rdata_q[7:0]}  : {{24{rdata_q[7]}},  rdata_q[7:0]};
      2'b01:   load_c = uns_q ? {16'b0, rdata_q[15:0]} : {{16{rdata_q[15]}}, rdata_q[15:0]};
      default: load_c = rdata_q;
    endcase
  end

  // Sub-word store merge into the word being read back
  always_comb begin
    merge_c = wdata_q;
    case (size_q)
      2'b00:   merge_c = {mem_dataout[31:8],  wdata_q[7:0]};
      2'b01:   merge_c = {mem_dataout[31:16], wdata_q[15:0]};
      default: merge_c = wdata_q;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    size_d       = size_q;
    we_d         = we_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    raddr_d      = raddr_q;
    waddr_d      = waddr_q;
    datain_d     = datain_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    resp_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          addr_d  = req_addr;
          size_d  = req_size;
          we_d    = req_we;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          cnt_d   = '0;
          if (req_size == 2'b11) begin
            state_d = RESP;
          end else if (req_we && req_size == 2'b10) begin
            state_d  = WRITE;
            waddr_d  = req_addr;
            datain_d = req_wdata;
          end else begin
            state_d = RD_WAIT;
            raddr_d = req_addr;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          rdata_d = mem_dataout;
          if (we_q) begin
            state_d  = WRITE;
            waddr_d  = addr_q;
            datain_d = merge_c;
          end else begin
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WRITE: state_d = RESP;
      RESP: begin
        // Response pulse lands one cycle after RESP, as state returns to IDLE
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_err_d   = (size_q == 2'b11);
        resp_rdata_d = (we_q || size_q == 2'b11) ? 32'h0 : load_c;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= 32'h0;
      size_q       <= 2'b00;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      raddr_q      <= 32'h0;
      waddr_q      <= 32'h0;
      datain_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      we_q         <= we_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      raddr_q      <= raddr_d;
      waddr_q      <= waddr_d;
      datain_q     <= datain_d;
    end
  end

  // Write strobe straight from the state register so reset kills it at once
  assign mem_wr       = (state_q == WRITE) ? 4'hF : 4'h0;
  assign req_ready    = ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign mem_raddress = raddr_q;
  assign mem_waddress = waddr_q;
  assign mem_datain   = datain_q;

endmodule
